// File: rtl/kf_dma_priority_arbiter.sv
// ---------------------------------------------------------------------------
// kf_dma_priority_arbiter
//
// Parametrised DMA request arbiter, successor to the 4-channel 8237 priority
// logic. It combines the request mask, software requests and per-channel
// edge/level sensing. It then selects a winner with fixed or rotating priority
// and offers a registered one-hot grant to the DMA timing controller, using a
// request/acknowledge/done handshake.
//
// Optional feature macro: KF_DMA_ARB_AUTOMASK_EN
//   When defined, a service that completes with eop also sets the mask bit of
//   the served channel (non-autoinit behaviour). A mask write to that same
//   channel in the same cycle takes precedence.
//
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   master_clear      one-cycle soft clear back to reset values
//   cfg_we/cfg_data   config: [0] disable, [1] rotating, [2] DREQ active-low
//   mask_single_we    write mask[mask_sel] = mask_val
//   mask_all_we       load mask = mask_all_data
//   mask_set_all      set every mask bit (also clears block-mode locks)
//   req_we            write soft_req[req_sel] = req_val
//   edge_mode         per channel: 1 = edge sensed (block mode), 0 = level
//   dreq              external requests (asynchronous)
//   grant_ack         timing FSM accepted the offered grant
//   service_done, eop service finished; eop marks terminal count
//   pending           effective eligible requests
//   grant_valid       grant offered or in service
//   grant_onehot/id   granted channel
//   busy              service in progress
// ---------------------------------------------------------------------------
module kf_dma_priority_arbiter #(
  parameter int CHANNELS = 4,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                master_clear,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_data,
  input  logic                mask_single_we,
  input  logic [SEL_W-1:0]    mask_sel,
  input  logic                mask_val,
  input  logic                mask_all_we,
  input  logic [CHANNELS-1:0] mask_all_data,
  input  logic                mask_set_all,
  input  logic                req_we,
  input  logic [SEL_W-1:0]    req_sel,
  input  logic                req_val,
  input  logic [CHANNELS-1:0] edge_mode,
  input  logic [CHANNELS-1:0] dreq,
  input  logic                grant_ack,
  input  logic                service_done,
  input  logic                eop,
  output logic [CHANNELS-1:0] pending,
  output logic                grant_valid,
  output logic [CHANNELS-1:0] grant_onehot,
  output logic [SEL_W-1:0]    grant_id,
  output logic                busy
);

  localparam logic [SEL_W-1:0]    LAST_ID   = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]      CHAN_CNT  = (SEL_W + 1)'(CHANNELS);
  localparam logic [CHANNELS-1:0] ONEHOT_0  = CHANNELS'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OFFER   = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t                state_r;
  logic [2:0]            cfg_r;
  logic [CHANNELS-1:0]   mask_r;
  logic [CHANNELS-1:0]   soft_req_r;
  logic [CHANNELS-1:0]   lock_r;
  logic [CHANNELS-1:0]   dreq_sync_r;
  logic [SEL_W-1:0]      ptr_r;
  logic                  grant_valid_r;
  logic [CHANNELS-1:0]   grant_onehot_r;
  logic [SEL_W-1:0]      grant_id_r;
  logic                  busy_r;

  logic [CHANNELS-1:0]   pending_s;
  logic                  done_fire_s;
  logic                  mask_sel_ok_s;
  logic                  req_sel_ok_s;
  logic [SEL_W-1:0]      search_base_s;
  logic [SEL_W-1:0]      winner_s;
  logic [SEL_W-1:0]      ptr_next_s;
  logic [CHANNELS-1:0]   mask_next_s;
  logic [CHANNELS-1:0]   soft_next_s;
  logic [CHANNELS-1:0]   lock_next_s;

  // First requesting channel found scanning upward from base, wrapping
  // around the channel count.
  function automatic logic [SEL_W-1:0] pick_winner(
    input logic [CHANNELS-1:0] req,
    input logic [SEL_W-1:0]    base
  );
    logic [SEL_W-1:0] win;
    logic [SEL_W-1:0] idx;
    logic             found;
    win   = {SEL_W{1'b0}};
    idx   = base;
    found = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      win   = (!found && req[idx]) ? idx : win;
      found = found | req[idx];
      idx   = (idx == LAST_ID) ? {SEL_W{1'b0}} : idx + SEL_W'(1);
    end
    return win;
  endfunction

  assign pending      = pending_s;
  assign grant_valid  = grant_valid_r;
  assign grant_onehot = grant_onehot_r;
  assign grant_id     = grant_id_r;
  assign busy         = busy_r;

  // Selects that do not name an existing channel are ignored.
  assign mask_sel_ok_s = ({1'b0, mask_sel} < CHAN_CNT);
  assign req_sel_ok_s  = ({1'b0, req_sel} < CHAN_CNT);
  assign done_fire_s   = (state_r == ST_SERVICE) && service_done;
  assign ptr_next_s    = (grant_id_r == LAST_ID) ? {SEL_W{1'b0}} : grant_id_r + SEL_W'(1);

  // Eligible requests and arbitration winner.
  always_comb begin
    pending_s = {CHANNELS{1'b0}};
    if (cfg_r[0]) begin
      pending_s = {CHANNELS{1'b0}};
    end else begin
      pending_s = (dreq_sync_r & ~lock_r & ~mask_r) | soft_req_r;
    end
    search_base_s = cfg_r[1] ? ptr_r : {SEL_W{1'b0}};
    winner_s      = pick_winner(pending_s, search_base_s);
  end

  // Next mask: set-all beats single-bit write beats whole-mask load.
  always_comb begin
    mask_next_s = mask_r;
    if (mask_set_all) begin
      mask_next_s = {CHANNELS{1'b1}};
    end else if (mask_single_we) begin
      if (mask_sel_ok_s) begin
        mask_next_s[mask_sel] = mask_val;
      end else begin
        mask_next_s = mask_r;
      end
    end else if (mask_all_we) begin
      mask_next_s = mask_all_data;
    end else begin
      mask_next_s = mask_r;
    end
`ifdef KF_DMA_ARB_AUTOMASK_EN
    // Terminal count masks the served channel unless software writes it now.
    if (done_fire_s && eop && !mask_set_all && !mask_all_we &&
        !(mask_single_we && (mask_sel == grant_id_r))) begin
      mask_next_s[grant_id_r] = 1'b1;
    end else begin
      mask_next_s = mask_next_s;
    end
`endif
  end

  // Next software requests: a register write overrides the eop clear.
  always_comb begin
    soft_next_s = soft_req_r;
    if (done_fire_s && eop) begin
      soft_next_s[grant_id_r] = 1'b0;
    end else begin
      soft_next_s = soft_req_r;
    end
    if (req_we && req_sel_ok_s) begin
      soft_next_s[req_sel] = req_val;
    end else begin
      soft_next_s = soft_next_s;
    end
  end

  // Next block-mode locks: set when an edge channel finishes service, held
  // only while its synchronised request stays asserted.
  always_comb begin
    lock_next_s = lock_r;
    if (done_fire_s && edge_mode[grant_id_r]) begin
      lock_next_s[grant_id_r] = 1'b1;
    end else begin
      lock_next_s = lock_r;
    end
    lock_next_s = lock_next_s & dreq_sync_r;
    if (mask_set_all) begin
      lock_next_s = {CHANNELS{1'b0}};
    end else begin
      lock_next_s = lock_next_s;
    end
  end

  // Configuration, request synchroniser, mask, soft requests and locks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cfg_r       <= 3'b000;
      mask_r      <= {CHANNELS{1'b1}};
      soft_req_r  <= {CHANNELS{1'b0}};
      lock_r      <= {CHANNELS{1'b0}};
      dreq_sync_r <= {CHANNELS{1'b0}};
    end else if (master_clear) begin
      cfg_r       <= 3'b000;
      mask_r      <= {CHANNELS{1'b1}};
      soft_req_r  <= {CHANNELS{1'b0}};
      lock_r      <= {CHANNELS{1'b0}};
      dreq_sync_r <= {CHANNELS{1'b0}};
    end else begin
      cfg_r       <= cfg_we ? cfg_data : cfg_r;
      mask_r      <= mask_next_s;
      soft_req_r  <= soft_next_s;
      lock_r      <= lock_next_s;
      // Polarity is corrected before the flop so dreq_sync_r is active-high.
      dreq_sync_r <= cfg_r[2] ? ~dreq : dreq;
    end
  end

  // Grant FSM with registered handshake outputs and rotation pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      ptr_r          <= {SEL_W{1'b0}};
      grant_valid_r  <= 1'b0;
      grant_onehot_r <= {CHANNELS{1'b0}};
      grant_id_r     <= {SEL_W{1'b0}};
      busy_r         <= 1'b0;
    end else if (master_clear) begin
      state_r        <= ST_IDLE;
      ptr_r          <= {SEL_W{1'b0}};
      grant_valid_r  <= 1'b0;
      grant_onehot_r <= {CHANNELS{1'b0}};
      grant_id_r     <= {SEL_W{1'b0}};
      busy_r         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          busy_r <= 1'b0;
          if (|pending_s) begin
            state_r        <= ST_OFFER;
            grant_valid_r  <= 1'b1;
            grant_id_r     <= winner_s;
            grant_onehot_r <= ONEHOT_0 << winner_s;
          end else begin
            state_r        <= ST_IDLE;
            grant_valid_r  <= 1'b0;
            grant_id_r     <= {SEL_W{1'b0}};
            grant_onehot_r <= {CHANNELS{1'b0}};
          end
        end
        ST_OFFER: begin
          // An acknowledge in the same cycle as a withdrawal still commits.
          if (grant_ack) begin
            state_r <= ST_SERVICE;
            busy_r  <= 1'b1;
          end else if (!pending_s[grant_id_r]) begin
            state_r        <= ST_IDLE;
            grant_valid_r  <= 1'b0;
            grant_id_r     <= {SEL_W{1'b0}};
            grant_onehot_r <= {CHANNELS{1'b0}};
            busy_r         <= 1'b0;
          end else begin
            state_r <= ST_OFFER;
            busy_r  <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (service_done) begin
            state_r        <= ST_IDLE;
            grant_valid_r  <= 1'b0;
            grant_id_r     <= {SEL_W{1'b0}};
            grant_onehot_r <= {CHANNELS{1'b0}};
            busy_r         <= 1'b0;
            // The served channel becomes lowest priority.
            ptr_r          <= cfg_r[1] ? ptr_next_s : ptr_r;
          end else begin
            state_r <= ST_SERVICE;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          grant_valid_r  <= 1'b0;
          grant_id_r     <= {SEL_W{1'b0}};
          grant_onehot_r <= {CHANNELS{1'b0}};
          busy_r         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kf_dma_priority_arbiter.sv
// ---------------------------------------------------------------------------
// tb_kf_dma_priority_arbiter
//
// Directed scenarios followed by randomised traffic. Outputs are compared
// every cycle against a transaction-level reference model of the arbiter.
// Build with +define+KF_DMA_ARB_AUTOMASK_EN to exercise the auto-mask
// variant; the model follows the same macro.
// ---------------------------------------------------------------------------
module tb_kf_dma_priority_arbiter;

  localparam int CH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          master_clear;
  logic          cfg_we;
  logic [2:0]    cfg_data;
  logic          mask_single_we;
  logic [1:0]    mask_sel;
  logic          mask_val;
  logic          mask_all_we;
  logic [CH-1:0] mask_all_data;
  logic          mask_set_all;
  logic          req_we;
  logic [1:0]    req_sel;
  logic          req_val;
  logic [CH-1:0] edge_mode;
  logic [CH-1:0] dreq;
  logic          grant_ack;
  logic          service_done;
  logic          eop;
  logic [CH-1:0] pending;
  logic          grant_valid;
  logic [CH-1:0] grant_onehot;
  logic [1:0]    grant_id;
  logic          busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: configuration, registers, and the grant phase
  // (0 = no grant, 1 = offered, 2 = being serviced).
  logic [2:0]    m_cfg;
  logic [CH-1:0] m_mask, m_soft, m_lock, m_dreqs;
  int            m_ptr, m_phase, m_gid;

  kf_dma_priority_arbiter #(.CHANNELS(CH)) dut (
    .clock(clock), .reset(reset), .master_clear(master_clear),
    .cfg_we(cfg_we), .cfg_data(cfg_data),
    .mask_single_we(mask_single_we), .mask_sel(mask_sel), .mask_val(mask_val),
    .mask_all_we(mask_all_we), .mask_all_data(mask_all_data),
    .mask_set_all(mask_set_all),
    .req_we(req_we), .req_sel(req_sel), .req_val(req_val),
    .edge_mode(edge_mode), .dreq(dreq),
    .grant_ack(grant_ack), .service_done(service_done), .eop(eop),
    .pending(pending), .grant_valid(grant_valid), .grant_onehot(grant_onehot),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CH-1:0] m_pending();
    if (m_cfg[0]) return '0;
    return (m_dreqs & ~m_lock & ~m_mask) | m_soft;
  endfunction

  task automatic model_reset();
    m_cfg = 3'b000; m_mask = '1; m_soft = '0; m_lock = '0; m_dreqs = '0;
    m_ptr = 0; m_phase = 0; m_gid = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    logic [CH-1:0] pend, old_dreqs;
    logic [2:0]    old_cfg;
    bit            done;
    int            base;
    bit            found;
    if (reset || master_clear) begin
      model_reset();
    end else begin
      pend      = m_pending();
      old_cfg   = m_cfg;
      old_dreqs = m_dreqs;
      done      = (m_phase == 2) && service_done;
      if (cfg_we) m_cfg = cfg_data;
      m_dreqs = old_cfg[2] ? ~dreq : dreq;
      if (mask_set_all) m_mask = '1;
      else if (mask_single_we) m_mask[mask_sel] = mask_val;
      else if (mask_all_we) m_mask = mask_all_data;
`ifdef KF_DMA_ARB_AUTOMASK_EN
      if (done && eop && !(mask_set_all || mask_all_we ||
                           (mask_single_we && int'(mask_sel) == m_gid)))
        m_mask[m_gid] = 1'b1;
`endif
      if (done && eop) m_soft[m_gid] = 1'b0;
      if (req_we) m_soft[req_sel] = req_val;
      if (done && edge_mode[m_gid]) m_lock[m_gid] = 1'b1;
      for (int c = 0; c < CH; c++) if (!old_dreqs[c]) m_lock[c] = 1'b0;
      if (mask_set_all) m_lock = '0;
      case (m_phase)
        0: if (pend != '0) begin
             base  = old_cfg[1] ? m_ptr : 0;
             found = 0;
             for (int k = 0; k < CH; k++) begin
               if (!found && pend[(base + k) % CH]) begin
                 m_gid = (base + k) % CH;
                 found = 1;
               end
             end
             m_phase = 1;
           end
        1: if (grant_ack) m_phase = 2;
           else if (!pend[m_gid]) m_phase = 0;
        default: if (service_done) begin
             m_phase = 0;
             if (old_cfg[1]) m_ptr = (m_gid + 1) % CH;
           end
      endcase
    end
  endtask

  task automatic check_outputs();
    bit            v;
    logic [CH-1:0] eh;
    v  = (m_phase != 0);
    eh = v ? (4'b0001 << m_gid) : 4'b0000;
    chk("pending", pending, m_pending());
    chk("grant_valid", grant_valid, v);
    chk("grant_onehot", grant_onehot, eh);
    chk("grant_id", grant_id, v ? m_gid : 0);
    chk("busy", busy, m_phase == 2);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (grant_valid === 1'b1) break;
      step();
    end
    chk("wait_grant", grant_valid, 1'b1);
  endtask

  task automatic ack_cycle();
    grant_ack = 1'b1; step(); grant_ack = 1'b0;
  endtask

  task automatic done_cycle(input logic e, input logic [CH-1:0] dreq_after);
    service_done = 1'b1; eop = e; dreq = dreq_after; step();
    service_done = 1'b0; eop = 1'b0;
  endtask

  int rot_seq[5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b1; master_clear = 1'b0; cfg_we = 1'b0; cfg_data = 3'b000;
    mask_single_we = 1'b0; mask_sel = 2'd0; mask_val = 1'b0;
    mask_all_we = 1'b0; mask_all_data = 4'b0000; mask_set_all = 1'b0;
    req_we = 1'b0; req_sel = 2'd0; req_val = 1'b0; edge_mode = 4'b0000;
    dreq = 4'b0000; grant_ack = 1'b0; service_done = 1'b0; eop = 1'b0;
    model_reset();
    step(); step();
    chk("reset_valid", grant_valid, 1'b0);
    chk("reset_pending", pending, 4'b0000);
    reset = 1'b0;
    step();

    // Fixed priority, dreq 1010: channel 1 first, then channel 3.
    mask_all_we = 1'b1; mask_all_data = 4'b0000; step(); mask_all_we = 1'b0;
    dreq = 4'b1010;
    step();
    chk("lat_cycle1_valid", grant_valid, 1'b0);
    step();
    chk("lat_cycle2_valid", grant_valid, 1'b1);
    chk("fixed_onehot", grant_onehot, 4'b0010);
    chk("fixed_id1", grant_id, 2'd1);
    dreq = 4'b1000;
    ack_cycle();
    chk("fixed_busy", busy, 1'b1);
    done_cycle(1'b0, 4'b1000);
    chk("fixed_idle_gap", grant_valid, 1'b0);
    step();
    chk("fixed_id3", grant_id, 2'd3);
    dreq = 4'b0000;
    ack_cycle();
    done_cycle(1'b0, 4'b0000);
    step();

    // Rotating priority with all requests held.
    cfg_we = 1'b1; cfg_data = 3'b010; step(); cfg_we = 1'b0;
    dreq = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_valid(10);
      chk("rot_id", grant_id, rot_seq[k]);
      ack_cycle();
      done_cycle(1'b0, (k == 4) ? 4'b0000 : 4'b1111);
    end
    cfg_we = 1'b1; cfg_data = 3'b000; step(); cfg_we = 1'b0;

    // Block-mode channel 2 locks until its request drops.
    edge_mode = 4'b0100; dreq = 4'b0100;
    wait_valid(10);
    chk("edge_id", grant_id, 2'd2);
    ack_cycle();
    done_cycle(1'b0, 4'b0100);
    for (int k = 0; k < 4; k++) step();
    chk("edge_locked", grant_valid, 1'b0);
    dreq = 4'b0000; step();
    dreq = 4'b0100;
    wait_valid(10);
    chk("edge_regrant", grant_id, 2'd2);
    ack_cycle();
    done_cycle(1'b0, 4'b0000);
    edge_mode = 4'b0000;
    step();

    // Software request on a fully masked controller.
    mask_set_all = 1'b1; step(); mask_set_all = 1'b0;
    req_we = 1'b1; req_sel = 2'd3; req_val = 1'b1; step(); req_we = 1'b0;
    wait_valid(10);
    chk("soft_id", grant_id, 2'd3);
    ack_cycle();
    done_cycle(1'b1, 4'b0000);
    for (int k = 0; k < 4; k++) step();
    chk("soft_cleared", grant_valid, 1'b0);
    chk("soft_pending", pending, 4'b0000);

    // Request withdrawn while offered.
    mask_all_we = 1'b1; mask_all_data = 4'b0000; step(); mask_all_we = 1'b0;
    dreq = 4'b0010;
    wait_valid(10);
    chk("wd_id", grant_id, 2'd1);
    dreq = 4'b0000;
    step(); step();
    chk("wd_valid", grant_valid, 1'b0);
    chk("wd_busy", busy, 1'b0);

    // Active-low requests, then master clear during service.
    mask_set_all = 1'b1; cfg_we = 1'b1; cfg_data = 3'b100; step();
    mask_set_all = 1'b0; cfg_we = 1'b0;
    dreq = 4'b1110; step();
    mask_all_we = 1'b1; mask_all_data = 4'b0000; step(); mask_all_we = 1'b0;
    wait_valid(10);
    chk("al_id", grant_id, 2'd0);
    ack_cycle();
    chk("al_busy", busy, 1'b1);
    master_clear = 1'b1; step(); master_clear = 1'b0;
    chk("mc_valid", grant_valid, 1'b0);
    chk("mc_busy", busy, 1'b0);
    chk("mc_onehot", grant_onehot, 4'b0000);
    step();
    chk("mc_mask_all", pending, 4'b0000);
    dreq = 4'b0000; step();

    // Asynchronous reset in the middle of a service.
    mask_all_we = 1'b1; mask_all_data = 4'b0000; step(); mask_all_we = 1'b0;
    dreq = 4'b0001;
    wait_valid(10);
    ack_cycle();
    reset = 1'b1; #1;
    chk("arst_valid", grant_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    model_reset();
    dreq = 4'b0000; step();
    reset = 1'b0; step();

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      master_clear   = ($urandom_range(0, 199) == 0);
      cfg_we         = ($urandom_range(0, 39) == 0);
      cfg_data       = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 7) == 0)};
      mask_set_all   = ($urandom_range(0, 59) == 0);
      mask_single_we = ($urandom_range(0, 9) == 0);
      mask_sel       = 2'($urandom_range(0, 3));
      mask_val       = ($urandom_range(0, 2) == 0);
      mask_all_we    = ($urandom_range(0, 29) == 0);
      mask_all_data  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      req_we         = ($urandom_range(0, 14) == 0);
      req_sel        = 2'($urandom_range(0, 3));
      req_val        = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) edge_mode = 4'($urandom_range(0, 15));
      dreq           = dreq ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      grant_ack      = ($urandom_range(0, 2) == 0);
      service_done   = ($urandom_range(0, 2) == 0);
      eop            = 1'($urandom_range(0, 1));
      step();
    end
    master_clear = 1'b0; cfg_we = 1'b0; mask_set_all = 1'b0;
    mask_single_we = 1'b0; mask_all_we = 1'b0; req_we = 1'b0;
    grant_ack = 1'b0; service_done = 1'b0; eop = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
